// File: rtl/countdown6_if.sv
`default_nettype none
// ============================================================================
// Module      : countdown6_if
// Description : Control/status bundle between the round FSM and the
//               countdown6 flight timer.
// Revision    : 1.0 - initial release
// ============================================================================
interface countdown6_if;
  logic       start;     // load load_val and begin counting
  logic [5:0] load_val;  // starting count
  logic       en;        // count enable (freezes prescaler and count when low)
  logic       abort;     // stop counting, return to idle
  logic [5:0] out;       // current count value
  logic       running;   // high while counting
  logic       done;      // one-cycle pulse on expiry
  logic       expired;   // level, high while expired

  // Timer side: consumes controls, produces status
  modport slave (
    input  start,
    input  load_val,
    input  en,
    input  abort,
    output out,
    output running,
    output done,
    output expired
  );

  // Controller side: produces controls, consumes status
  modport master (
    output start,
    output load_val,
    output en,
    output abort,
    input  out,
    input  running,
    input  done,
    input  expired
  );
endinterface
`default_nettype wire

// File: rtl/countdown6.sv
`default_nettype none
// ============================================================================
// Module      : countdown6
// Description : Loadable 6-bit down-counter with a 26-bit prescaler. Counts
//               from load_val to zero in steps of DIV enabled cycles, then
//               pulses done for one cycle and parks in EXPIRED.
// Revision    : 1.0 - initial release
// ============================================================================
module countdown6 #(
  parameter int unsigned DIV = 50_000_000  // enabled cycles per step, 1..2^26-1
) (
  input  logic         clk_i,
  input  logic         clr_i,   // synchronous, active-low
  countdown6_if.slave  tmr
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_EXPIRED = 2'd2
  } state_t;

  // Terminal prescaler value; the step fires when the prescaler sits here
  localparam logic [25:0] PRESC_LAST = 26'(DIV - 1);

  state_t      state_q, state_d;
  logic [5:0]  out_q,   out_d;
  logic [25:0] presc_q, presc_d;
  logic        done_q,  done_d;

  // Next-state logic: abort beats start, start beats counting
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    presc_d = presc_q;
    done_d  = 1'b0;

    if (tmr.abort) begin
      // Count value is kept so the controller can read the remaining time
      state_d = S_IDLE;
      presc_d = '0;
    end else if (tmr.start) begin
      out_d   = tmr.load_val;
      presc_d = '0;
      if (tmr.load_val != 6'd0) begin
        state_d = S_RUN;
      end else begin
        // Zero-length flight expires on the load edge itself
        state_d = S_EXPIRED;
        done_d  = 1'b1;
      end
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (tmr.en) begin
            if (presc_q == PRESC_LAST) begin
              presc_d = '0;
              // RUN is only entered with a non-zero count, so out_q==0 never
              // occurs here; folding it into the expiry branch keeps the
              // counter from wrapping regardless.
              if (out_q <= 6'd1) begin
                out_d   = 6'd0;
                state_d = S_EXPIRED;
                done_d  = 1'b1;
              end else begin
                out_d = out_q - 6'd1;
              end
            end else begin
              presc_d = presc_q + 26'd1;
            end
          end
        end
        S_EXPIRED: begin
          out_d = 6'd0;
        end
        default: begin
          // IDLE: everything holds until start
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State register with synchronous active-low clear
  always_ff @(posedge clk_i) begin
    if (!clr_i) begin
      state_q <= S_IDLE;
      out_q   <= 6'd0;
      presc_q <= 26'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      presc_q <= presc_d;
      done_q  <= done_d;
    end
  end

  // Status is decoded straight from registers: no input-to-output path
  assign tmr.out     = out_q;
  assign tmr.running = (state_q == S_RUN);
  assign tmr.expired = (state_q == S_EXPIRED);
  assign tmr.done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_countdown6.sv
`default_nettype none
// ============================================================================
// Module      : tb_countdown6
// Description : Scoreboard bench for countdown6 with DIV=4. Stimulus pushes
//               the expected post-edge outputs; a monitor pops and compares
//               one entry after every rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown6;

  typedef struct {
    logic [5:0] out;
    logic       run;
    logic       done;
    logic       exp;
    string      tag;
  } exp_t;

  logic clk;
  logic clr;
  int   errors;
  int   checks;
  exp_t exp_q[$];

  countdown6_if tmr();

  countdown6 #(.DIV(4)) dut (
    .clk_i (clk),
    .clr_i (clr),
    .tmr   (tmr)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs and record what the outputs must be after the edge
  task automatic cyc(input logic c, input logic st, input logic [5:0] lv,
                     input logic e, input logic ab,
                     input logic [5:0] eo, input logic er, input logic ed,
                     input logic ex, input string tag);
    exp_t x;
    clr          = c;
    tmr.start    = st;
    tmr.load_val = lv;
    tmr.en       = e;
    tmr.abort    = ab;
    x.out = eo; x.run = er; x.done = ed; x.exp = ex; x.tag = tag;
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  // Monitor: compare outputs shortly after each rising edge
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      checks++;
      if ({tmr.out, tmr.running, tmr.done, tmr.expired} !==
          {x.out, x.run, x.done, x.exp}) begin
        errors++;
        $display("FAIL %s: got out=%0d running=%b done=%b expired=%b, want out=%0d running=%b done=%b expired=%b",
                 x.tag, tmr.out, tmr.running, tmr.done, tmr.expired,
                 x.out, x.run, x.done, x.exp);
      end
    end
  end

  // Directed stimulus
  initial begin
    logic [5:0] eo;
    logic       en_v;
    int         n;
    errors = 0;
    checks = 0;
    clr = 1'b0;
    tmr.start = 1'b0; tmr.load_val = 6'd0; tmr.en = 1'b0; tmr.abort = 1'b0;
    @(negedge clk);

    // Reset held with start asserted
    cyc(0, 1, 6'd9, 1, 0, 6'd0, 0, 0, 0, "reset0");
    cyc(0, 1, 6'd9, 1, 0, 6'd0, 0, 0, 0, "reset1");

    // load 3, en held high: done after edge 12
    cyc(1, 1, 6'd3, 1, 0, 6'd3, 1, 0, 0, "run3_load");
    for (int e = 1; e <= 15; e++) begin
      eo = (e < 12) ? 6'(3 - e / 4) : 6'd0;
      cyc(1, 0, 6'd0, 1, 0, eo, e < 12, e == 12, e >= 12, "run3");
    end

    // Same, with en low for edges 6..10: done moves to edge 17
    cyc(1, 1, 6'd3, 1, 0, 6'd3, 1, 0, 0, "gap_load");
    n = 0;
    for (int e = 1; e <= 20; e++) begin
      en_v = !(e >= 6 && e <= 10);
      if (en_v) n++;
      eo = (n < 12) ? 6'(3 - n / 4) : 6'd0;
      cyc(1, 0, 6'd0, en_v, 0, eo, n < 12, en_v && n == 12, n >= 12, "gap");
    end

    // Zero load expires on the load edge
    cyc(1, 1, 6'd0, 1, 0, 6'd0, 0, 1, 1, "zero_load");
    for (int e = 1; e <= 3; e++)
      cyc(1, 0, 6'd0, 1, 0, 6'd0, 0, 0, 1, "zero_hold");

    // Restart mid-run at out=2 with load 5: done exactly 20 cycles later
    cyc(1, 1, 6'd3, 1, 0, 6'd3, 1, 0, 0, "rst_load");
    for (int e = 1; e <= 4; e++)
      cyc(1, 0, 6'd0, 1, 0, (e < 4) ? 6'd3 : 6'd2, 1, 0, 0, "rst_pre");
    cyc(1, 1, 6'd5, 1, 0, 6'd5, 1, 0, 0, "restart");
    for (int e = 1; e <= 21; e++) begin
      eo = (e < 20) ? 6'(5 - e / 4) : 6'd0;
      cyc(1, 0, 6'd0, 1, 0, eo, e < 20, e == 20, e >= 20, "restart_run");
    end

    // Abort mid-run at out=2: count holds, no done
    cyc(1, 1, 6'd3, 1, 0, 6'd3, 1, 0, 0, "abt_load");
    for (int e = 1; e <= 4; e++)
      cyc(1, 0, 6'd0, 1, 0, (e < 4) ? 6'd3 : 6'd2, 1, 0, 0, "abt_pre");
    cyc(1, 0, 6'd0, 1, 1, 6'd2, 0, 0, 0, "abort");
    for (int e = 1; e <= 6; e++)
      cyc(1, 0, 6'd0, 1, 0, 6'd2, 0, 0, 0, "idle_hold");

    // Abort and start together: abort wins, count holds
    cyc(1, 1, 6'd3, 1, 0, 6'd3, 1, 0, 0, "both_load");
    cyc(1, 1, 6'd9, 1, 1, 6'd3, 0, 0, 0, "abort_start");
    cyc(1, 0, 6'd0, 1, 0, 6'd3, 0, 0, 0, "both_after");

    // Reset on the expiry edge suppresses done
    cyc(1, 1, 6'd1, 1, 0, 6'd1, 1, 0, 0, "clr_load");
    for (int e = 1; e <= 3; e++)
      cyc(1, 0, 6'd0, 1, 0, 6'd1, 1, 0, 0, "clr_pre");
    cyc(0, 0, 6'd0, 1, 0, 6'd0, 0, 0, 0, "clr_expiry");
    cyc(1, 0, 6'd0, 1, 0, 6'd0, 0, 0, 0, "clr_after0");
    cyc(1, 0, 6'd0, 1, 0, 6'd0, 0, 0, 0, "clr_after1");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
